// File: rtl/pio_pkg.sv
// Shared constants for the switch/button PIO.
//   Register word addresses and the EDGE_MODE encodings.
//   A small bus command struct that the top decodes once per cycle.
package pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Decoded bus write request for one cycle
  typedef struct packed {
    logic       wr;
    logic [1:0] addr;
  } pio_cmd_t;

endpackage

// File: rtl/pio_debounce_bit.sv
// One input lane: synchroniser chain, debounce counter and the
// debounced (stable) flop.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   din          : raw asynchronous input bit
//   stable       : debounced value, changes only after DEBOUNCE_CYCLES
//                  consecutive synchronised samples differ from it
module pio_debounce_bit #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic stable
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CNT_W-1:0]       cnt;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      // Any sample equal to the stable value restarts the count, so only
      // an unbroken run of differing samples is accepted.
      if (sync == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pio_sw_edge_irq.sv
// Input PIO for switches/buttons on Avalon-MM with per-bit debounce,
// sticky edge capture and a maskable level interrupt.
// Registers: 0 data (debounced, RO), 1 reserved (reads 0),
//            2 irqmask (RW), 3 edgecapture (write-1-to-clear).
// Ports:
//   clk, reset_n         : clock, async active-low reset
//   address, chipselect,
//   write_n, writedata   : Avalon-MM slave write/select
//   readdata             : registered read data, 1-cycle latency
//   in_port              : raw asynchronous inputs
//   irq                  : registered level interrupt
module pio_sw_edge_irq
  import pio_pkg::*;
#(
  parameter int WIDTH           = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_MODE       = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] stable, stable_d;
  logic [WIDTH-1:0] rise, fall, edge_v;
  logic [WIDTH-1:0] irqmask, edgecap;
  logic [WIDTH-1:0] clr_mask, rd_mux;
  pio_cmd_t         cmd;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    pio_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (in_port[i]),
      .stable (stable[i])
    );
  end

  assign cmd.wr   = chipselect & ~write_n;
  assign cmd.addr = address;

  // stable_d resets to 0, so an input held high through reset shows up
  // as a rising edge once it is debounced.
  assign rise   = stable & ~stable_d;
  assign fall   = ~stable & stable_d;
  assign edge_v = (EDGE_MODE == EDGE_RISE) ? rise :
                  (EDGE_MODE == EDGE_FALL) ? fall : (rise | fall);

  assign clr_mask = (cmd.wr && cmd.addr == PIO_ADDR_EDGECAP) ? writedata : '0;

  always_comb begin
    rd_mux = '0;
    case (address)
      PIO_ADDR_DATA:    rd_mux = stable;
      PIO_ADDR_RSVD:    rd_mux = '0;
      PIO_ADDR_IRQMASK: rd_mux = irqmask;
      PIO_ADDR_EDGECAP: rd_mux = edgecap;
      default:          rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_d <= '0;
      irqmask  <= '0;
      edgecap  <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      stable_d <= stable;
      if (cmd.wr && cmd.addr == PIO_ADDR_IRQMASK)
        irqmask <= writedata;
      // OR-ing the new edge in after the clear lets a same-cycle edge win
      edgecap  <= (edgecap & ~clr_mask) | edge_v;
      readdata <= rd_mux;
      irq      <= |(edgecap & irqmask);
    end
  end

endmodule

// File: tb/tb_pio_sw_edge_irq.sv
module tb_pio_sw_edge_irq;

  localparam int W = 10;
  localparam int S = 2;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [1:0]   address;
  logic         chipselect;
  logic         write_n;
  logic [W-1:0] writedata;
  logic [W-1:0] in_port;
  logic [W-1:0] dut_rd [3];
  logic         dut_irq [3];

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  // One instance per edge mode, all driven by the same stimulus
  for (genvar g = 0; g < 3; g++) begin : g_dut
    pio_sw_edge_irq #(
      .WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .EDGE_MODE(g)
    ) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .address   (address),
      .chipselect(chipselect),
      .write_n   (write_n),
      .writedata (writedata),
      .readdata  (dut_rd[g]),
      .in_port   (in_port),
      .irq       (dut_irq[g])
    );
  end

  // ---------------- behavioural model ----------------
  // hist[j] holds the in_port sample taken j+1 clock edges ago.
  // The debounced value flips when the D samples the debouncer sees all
  // disagree with it.
  logic [W-1:0] hist [S+D];
  logic [W-1:0] m_stable, m_mask, m_rise_ev, m_fall_ev;
  logic [W-1:0] m_ecap [3];
  logic [W-1:0] m_rd [3];
  logic         m_irq [3];
  logic [W-1:0] t_stable, t_ev, t_clr;
  bit           t_alldiff;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < S + D; j++) hist[j] = '0;
      m_stable = '0; m_mask = '0; m_rise_ev = '0; m_fall_ev = '0;
      for (int m = 0; m < 3; m++) begin
        m_ecap[m] = '0; m_rd[m] = '0; m_irq[m] = 1'b0;
      end
    end else begin
      t_stable = m_stable;
      for (int b = 0; b < W; b++) begin
        t_alldiff = 1'b1;
        for (int j = S - 1; j <= S + D - 2; j++)
          if (hist[j][b] == m_stable[b]) t_alldiff = 1'b0;
        if (t_alldiff) t_stable[b] = ~m_stable[b];
      end
      t_clr = (chipselect && !write_n && address == 2'd3) ? writedata : '0;
      for (int m = 0; m < 3; m++) begin
        t_ev = (m == 0) ? m_rise_ev : (m == 1) ? m_fall_ev : (m_rise_ev | m_fall_ev);
        case (address)
          2'd0: m_rd[m] = m_stable;
          2'd1: m_rd[m] = '0;
          2'd2: m_rd[m] = m_mask;
          default: m_rd[m] = m_ecap[m];
        endcase
        m_irq[m]  = |(m_ecap[m] & m_mask);
        m_ecap[m] = (m_ecap[m] & ~t_clr) | t_ev;
      end
      if (chipselect && !write_n && address == 2'd2) m_mask = writedata;
      m_rise_ev = t_stable & ~m_stable;
      m_fall_ev = ~t_stable & m_stable;
      m_stable  = t_stable;
      for (int j = S + D - 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = in_port;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int m = 0; m < 3; m++) begin
        n_cmp++;
        if (dut_rd[m] !== m_rd[m] || dut_irq[m] !== m_irq[m]) begin
          n_bad++;
          $display("FAIL cyc_mode%0d t=%0t: readdata=%h irq=%b, want readdata=%h irq=%b",
                   m, $time, dut_rd[m], dut_irq[m], m_rd[m], m_irq[m]);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [W-1:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [1:0] a);
    address = a;
    tick();
  endtask

  task automatic async_reset_check(input string nm);
    #2 reset_n = 1'b0;
    #1;
    for (int m = 0; m < 3; m++) begin
      check({nm, "_rd"}, dut_rd[m], '0);
      check({nm, "_irq"}, {{(W-1){1'b0}}, dut_irq[m]}, '0);
    end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0;
    tick(3);
    reset_n = 1'b1;
    cmp_en = 1'b1;

    // Build up some state, then reset mid-run with inputs held high
    bus_wr(2'd2, 10'h155);
    in_port = 10'h3FF;
    tick(10);
    check("pre_reset_ecap_model", m_ecap[0], 10'h3FF);
    async_reset_check("reset_async");
    bus_rd(2'd2);
    check("reset_irqmask", dut_rd[0], 10'h000);
    bus_rd(2'd3);
    check("reset_ecap", dut_rd[0], 10'h000);
    address = 2'd0;
    tick(5);                               // 7 edges since release
    check("powerup_data", dut_rd[0], 10'h3FF);
    bus_rd(2'd3);
    check("powerup_ecap_rise", dut_rd[0], 10'h3FF);
    check("powerup_ecap_fall", dut_rd[1], 10'h000);
    check("powerup_ecap_any",  dut_rd[2], 10'h3FF);
    check("powerup_ecap_model", m_ecap[0], 10'h3FF);

    // Bounce rejection on bit 0: 3-cycle pulses never get accepted
    in_port = '0;
    tick(10);
    bus_wr(2'd3, 10'h3FF);
    for (int r = 0; r < 3; r++) begin
      in_port[0] = 1'b1; tick(3);
      in_port[0] = 1'b0; tick(3);
    end
    tick(4);
    bus_rd(2'd0);
    check("bounce_data", dut_rd[0], 10'h000);
    bus_rd(2'd3);
    check("bounce_ecap", dut_rd[0], 10'h000);
    in_port[0] = 1'b1;
    tick(8);
    bus_rd(2'd0);
    check("held_data", dut_rd[0], 10'h001);
    bus_rd(2'd3);
    check("held_ecap", dut_rd[0], 10'h001);

    // Interrupt flow
    in_port[0] = 1'b0;
    tick(10);
    bus_wr(2'd3, 10'h3FF);
    bus_wr(2'd2, 10'h001);
    in_port[0] = 1'b1;
    tick(10);
    check("irq_rise", {{(W-1){1'b0}}, dut_irq[0]}, 10'h001);
    check("irq_fallmode_quiet", {{(W-1){1'b0}}, dut_irq[1]}, 10'h000);
    bus_wr(2'd3, 10'h001);
    tick();
    check("irq_cleared", {{(W-1){1'b0}}, dut_irq[0]}, 10'h000);
    in_port[5] = 1'b1;
    tick(10);
    check("irq_masked_bit5", {{(W-1){1'b0}}, dut_irq[0]}, 10'h000);
    bus_rd(2'd3);
    check("ecap_bit5", dut_rd[0], 10'h020);

    // Edge on bit 3 lands on the same cycle as its W1C
    in_port[3] = 1'b1;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        tick();
        seen = m_stable[3];
      end
      if (!seen) begin
        n_cmp++; n_bad++;
        $display("FAIL collide_wait: bit3 never debounced, want debounced within 20 cycles");
      end
    end
    bus_wr(2'd3, 10'h008);
    bus_rd(2'd3);
    check("collide_set_wins", dut_rd[0], 10'h028);

    // Register access
    bus_wr(2'd2, 10'h2AA);                 // address 2 held: pre-write value
    check("mask_prewrite", dut_rd[0], 10'h001);
    tick();
    check("mask_rw", dut_rd[0], 10'h2AA);
    bus_wr(2'd0, 10'h3FF);
    bus_wr(2'd1, 10'h3FF);
    bus_rd(2'd1);
    check("rsvd_zero", dut_rd[0], 10'h000);
    bus_rd(2'd0);
    check("data_ro", dut_rd[0], 10'h029);
    bus_rd(2'd2);
    check("mask_kept", dut_rd[0], 10'h2AA);

    // Edge modes on bit 9
    bus_wr(2'd3, 10'h3FF);
    in_port[9] = 1'b1;
    tick(10);
    bus_rd(2'd3);
    check("b9_rise_m0", dut_rd[0], 10'h200);
    check("b9_rise_m1", dut_rd[1], 10'h000);
    check("b9_rise_m2", dut_rd[2], 10'h200);
    bus_wr(2'd3, 10'h3FF);
    in_port[9] = 1'b0;
    tick(10);
    bus_rd(2'd3);
    check("b9_fall_m0", dut_rd[0], 10'h000);
    check("b9_fall_m1", dut_rd[1], 10'h200);
    check("b9_fall_m2", dut_rd[2], 10'h200);

    // Randomised traffic with slow, bouncy inputs and random bus ops
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0)
        in_port = in_port ^ (W'(1) << $urandom_range(0, W-1));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = 1'($urandom_range(0, 1));
      address    = 2'($urandom_range(0, 3));
      writedata  = W'($urandom);
      if (i == 2000) async_reset_check("reset_random");
      else tick();
    end
    chipselect = 1'b0; write_n = 1'b1;
    tick(2);
    cmp_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pio_sw_edge_irq.md
Name: pio_sw_edge_irq

Overview:
Parametrised input PIO for switches and buttons on the Avalon-MM system bus. It replaces the fixed 10-bit, read-only switch port. Each input bit is synchronised, debounced and edge-detected into a sticky edge-capture register, and the block raises a maskable level interrupt to the CPU. Register map: 0 = data, 2 = irqmask, 3 = edgecapture; address 1 is reserved.

Parameters:
WIDTH, 10, number of input bits (1..32)
SYNC_STAGES, 2, flip-flop stages in the input synchroniser (>=2)
DEBOUNCE_CYCLES, 50000, consecutive clk cycles an input must differ from its stable value before acceptance (>=1)
EDGE_MODE, 0, edges captured: 0 = rising, 1 = falling, 2 = any
CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived, not overridden)

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous, active-low
address  in  2  Avalon word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  WIDTH  write data
readdata  out  WIDTH  registered read data
in_port  in  WIDTH  raw asynchronous switch inputs
irq  out  1  level interrupt, active-high

Behaviour:
- Reset values: all of the following are 0 — readdata, irq, synchroniser flops, debounced value, debounce counters, irqmask, edgecapture, edge-detect delay register.
- Reset is asynchronous assert and is honoured at any time. Reset in the middle of a debounce discards the partial count.
- Synchroniser:
  - sync[i] = in_port[i] after SYNC_STAGES flops.
  - No other logic samples in_port.
- Debounce, per bit, independent:
  - If sync == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync, cnt <= 0.
  - Else: cnt <= cnt+1.
  - A change is therefore accepted after exactly DEBOUNCE_CYCLES consecutive differing cycles. Any bounce back to the stable value restarts the count.
  - With DEBOUNCE_CYCLES=1, stable follows sync with 1 cycle delay.
- Edge detect: stable_d <= stable each cycle.
  - rise = stable & ~stable_d
  - fall = ~stable & stable_d
  - edge is selected by EDGE_MODE.
- Edges are visible in edgecapture on the cycle after stable changes.
- The power-up transition is a real edge: after reset, an input held high produces a rising edge once debounced.
- edgecapture (sticky):
  - Bit set on an edge.
  - Cleared by a write to address 3 with 1s in writedata (write-1-to-clear); 0 bits are unaffected.
  - An edge and a clear on the same bit in the same cycle: set wins.
- irqmask: read/write at address 2. Full-width write; no byte enables.
- irq: registered, irq <= |(edgecapture & irqmask) evaluated from register values, so it asserts 1 cycle after the edgecapture bit sets. It deasserts 1 cycle after the capture bit is cleared or the mask bit is cleared.
- Writes: accepted when chipselect & ~write_n. Writes to addresses 0 and 1 are ignored.
- Reads:
  - readdata <= mux(address) every cycle, regardless of chipselect; 1-cycle read latency.
  - address 0 = stable (debounced value, not raw).
  - address 1 = 0.
  - address 2 = irqmask.
  - address 3 = edgecapture.
- Same-cycle read and write of one register: readdata returns the pre-write value.
- Counter width: cnt never exceeds DEBOUNCE_CYCLES-1; no wrap-around is reachable.

Decomposition:
- Shared package pio_pkg:
  - address constants PIO_ADDR_DATA=0, PIO_ADDR_IRQMASK=2, PIO_ADDR_EDGECAP=3
  - edge mode constants EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2
- Sub-module pio_debounce_bit: synchroniser plus debounce counter plus stable flop for one bit, parameters SYNC_STAGES and DEBOUNCE_CYCLES. Instantiated WIDTH times in a generate loop.
- Top level holds the edge logic, registers, read mux and irq.

Test Plan:
- Bench configuration for all scenarios: WIDTH=10, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, EDGE_MODE=0.
- Reset and idle: assert reset_n=0 mid-run with in_port=10'h3FF -> readdata, irq, irqmask and edgecapture all 0 immediately. After release, read addr 0 at cycle >= 2+4+1 -> 10'h3FF; addr 3 -> 10'h3FF.
- Bounce rejection: in_port[0] toggles 0->1->0 with a 3-cycle high pulse, repeated -> addr 0 bit0 stays 0 and edgecapture stays 0. Holding it high for 4 cycles -> bit0=1 and edgecapture[0]=1.
- Interrupt flow:
  - Write irqmask=10'h001, then apply a debounced rise on bit 0 -> irq=1 one cycle after edgecapture[0] sets.
  - Write addr 3 with 10'h001 -> edgecapture=0 and irq=0 the next cycle.
  - A rise on bit 5 with mask bit 5 clear -> edgecapture[5]=1, irq stays 0.
- Set versus clear collision: a W1C of bit 3 lands on the same cycle bit 3's edge is detected -> edgecapture[3] reads 1 afterwards.
- Register access: write 10'h2AA to addr 2 then read -> 10'h2AA with 1-cycle latency. Writes to addr 0 and addr 1 have no effect; a read of addr 1 returns 0.
- Edge modes:
  - Rerun with EDGE_MODE=1: a falling debounced transition on bit 9 sets edgecapture[9]; a rising one does not.
  - With EDGE_MODE=2: both directions set it.
